usb_audio_i2s_tx: RTL

USB_AUDIO_I2S_TX -- requirements
Module: usb_audio_i2s_tx

---
 rtl/usb_audio_pkg.sv | 12 +
 rtl/usb_audio_fifo.sv | 66 ++++++
 rtl/usb_audio_i2s_tx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/usb_audio_pkg.sv
// Shared constants for the USB audio output path.
package usb_audio_pkg;

    // Every channel occupies a fixed 32-BCLK slot regardless of sample width.
    localparam int unsigned SLOT_W   = 32;
    localparam int unsigned SLOT_LOG = $clog2(SLOT_W);

    // Serial format selection for the MODE parameter.
    localparam int unsigned MODE_I2S = 0;  // data lags LRCLK edge by one BCLK
    localparam int unsigned MODE_LJ  = 1;  // data aligned with LRCLK edge

endpackage

// File: rtl/usb_audio_fifo.sv
// Synchronous frame FIFO with first-word fall-through read and level output.
module usb_audio_fifo
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 16
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    output logic                       full,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    // Push/pop qualified by the occupancy at the start of the cycle.
    always_comb begin
        full    = (count == (AW+1)'(DEPTH));
        empty   = (count == '0);
        push    = wr_en && !full;
        pop     = rd_en && !empty;
        rd_data = mem[rd_ptr];
        level   = count;
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/usb_audio_i2s_tx.sv
// Multichannel I2S / left-justified serializer fed from a frame FIFO.
module usb_audio_i2s_tx
    import usb_audio_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter int unsigned SW       = 16,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned BCLK_DIV = 10,
    parameter int unsigned MODE     = 0,
    parameter int unsigned HOLD     = 0
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NCH*SW-1:0]          in_data,
    output logic                       i2s_bclk,
    output logic                       i2s_lrclk,
    output logic                       i2s_sdata,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       underrun
);

    localparam int unsigned FW         = NCH * SW;
    localparam int unsigned FRAME_BITS = NCH * SLOT_W;
    localparam int unsigned BW         = $clog2(FRAME_BITS);
    localparam int unsigned DW         = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DW-1:0] div_q;
    logic          div_end;
    logic          fall;
    logic          wrap;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] next_bit;
    logic [FW-1:0] shift_q;
    logic [FW-1:0] last_q;
    logic [FW-1:0] load_frame;
    logic [FW-1:0] next_shift;
    logic [FW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [SW-1:0] sample;
    int unsigned   slot_idx;
    int unsigned   k_idx;
    logic          lj_bit;
    logic          lj_bit_q;
    logic          next_lr;

    assign in_ready = !fifo_full;

    usb_audio_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .full    (fifo_full),
        .rd_en   (wrap),
        .rd_data (fifo_dout),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // BCLK generator: toggle every BCLK_DIV clk cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            i2s_bclk <= 1'b0;
        end else if (div_end) begin
            div_q    <= '0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            div_q    <= div_q + DW'(1);
        end
    end

    // Next bit position, frame load and the left-justified bit for that position.
    // The bit is taken from the frame that will be current after this fall event,
    // so frame bit 0 already sees the freshly loaded frame.
    always_comb begin
        div_end    = (div_q == DW'(BCLK_DIV - 1));
        fall       = div_end && i2s_bclk;
        wrap       = fall && (bit_cnt == BW'(FRAME_BITS - 1));
        next_bit   = (bit_cnt == BW'(FRAME_BITS - 1)) ? '0 : bit_cnt + BW'(1);
        load_frame = !fifo_empty ? fifo_dout : ((HOLD != 0) ? last_q : '0);
        next_shift = wrap ? load_frame : shift_q;
        slot_idx   = 32'(next_bit) >> SLOT_LOG;
        k_idx      = 32'(next_bit[SLOT_LOG-1:0]);
        sample     = SW'(next_shift >> (slot_idx * SW));
        lj_bit     = (k_idx < SW) ? 1'(sample >> (SW - 1 - k_idx)) : 1'b0;
        next_lr    = (slot_idx >= NCH / 2);
    end

    // Serializer state: advances only on BCLK fall events.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= BW'(FRAME_BITS - 1);
            shift_q   <= '0;
            last_q    <= '0;
            lj_bit_q  <= 1'b0;
            i2s_sdata <= 1'b0;
            i2s_lrclk <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= wrap && fifo_empty;
            if (fall) begin
                bit_cnt   <= next_bit;
                shift_q   <= next_shift;
                lj_bit_q  <= lj_bit;
                i2s_lrclk <= next_lr;
                i2s_sdata <= (MODE == MODE_LJ) ? lj_bit : lj_bit_q;
                if (wrap) begin
                    last_q <= load_frame;
                end
            end
        end
    end

endmodule
